// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential N-bit ALU.
//   OP_W        : opcode width (fixed at 3, eight opcodes, all legal)
//   alu_op_e    : opcode encoding ADD..XOR
//   alu_state_e : control FSM states
//   is_div_op() : true for opcodes that run on the iterative divider
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpMul = 3'd2,
        OpDiv = 3'd3,
        OpRem = 3'd4,
        OpAnd = 3'd5,
        OpOr  = 3'd6,
        OpXor = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StHold = 2'd2
    } alu_state_e;

    function automatic logic is_div_op(alu_op_e op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/alu_div_seq.sv
// alu_div_seq: WIDTH-bit unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : load operands (one cycle pulse)
//   dividend, divisor   : operands, sampled when start is high
//   done                : high during the cycle of the final iteration
//   quotient, remainder : result of the iteration in progress; valid when done is high,
//                         so the parent registers them on the same edge as the last step
//   dz                  : divisor was zero (quotient comes out all ones, remainder = dividend)
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, dz_q;

    logic [WIDTH:0]   rem_sh, trial;
    logic             fits;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    // With a zero divisor every trial fits, which yields all-ones quotient and
    // remainder = dividend without any special casing.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dsr_q};
        fits   = ~trial[WIDTH];
        rem_nx = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], fits};
    end

    assign done      = busy_q && (cnt_q == LAST);
    assign quotient  = quo_nx;
    assign remainder = rem_nx;
    assign dz        = dz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dsr_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            dz_q   <= (divisor == '0);
        end else if (busy_q) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit: registered N-bit ALU with valid/ready on both sides, status flags
// and a multi-cycle restoring divider. Holds exactly one result.
// Optional feature macro: ALU_MUL_HI_EN (drives out_hi with the MUL upper half;
// otherwise out_hi is tied to 0 and no high-half register exists).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : input handshake; in1, in2 operands; sel opcode
//   out_valid/out_ready : output handshake
//   out, out_hi         : result low half, MUL high half
//   flag_c, flag_z      : carry/borrow/product overflow, result is zero
//   flag_dz             : divide by zero
module alu_seq_nbit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [OP_W-1:0]  sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_dz
);

    alu_state_e state_q, state_d;
    alu_op_e    op;

    logic [WIDTH-1:0]   out_q, out_d;
    logic               c_q, c_d, z_q, dz_q, dz_d;
    logic               is_rem_q;
    logic               load, accept;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;

    logic               div_start, div_done, div_dz;
    logic [WIDTH-1:0]   div_quo, div_rem;

`ifdef ALU_MUL_HI_EN
    logic [WIDTH-1:0] hi_q, hi_d;
`endif

    assign op = alu_op_e'(sel);

    // Gated by rst_n so nothing is offered upstream while reset is held.
    assign in_ready = rst_n && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
    assign accept   = in_valid && in_ready;

    assign sum  = {1'b0, in1} + {1'b0, in2};
    assign diff = {1'b0, in1} - {1'b0, in2};
    assign prod = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        div_start = 1'b0;
        out_d     = out_q;
        c_d       = 1'b0;
        dz_d      = 1'b0;
`ifdef ALU_MUL_HI_EN
        hi_d      = '0;
`endif
        unique case (state_q)
            StIdle, StHold: begin
                if (accept) begin
                    if (is_div_op(op)) begin
                        div_start = 1'b1;
                        state_d   = StBusy;
                    end else begin
                        load    = 1'b1;
                        state_d = StHold;
                        unique case (op)
                            OpAdd: begin
                                out_d = sum[WIDTH-1:0];
                                c_d   = sum[WIDTH];
                            end
                            OpSub: begin
                                out_d = diff[WIDTH-1:0];
                                c_d   = diff[WIDTH];
                            end
                            OpMul: begin
                                out_d = prod[WIDTH-1:0];
                                c_d   = |prod[2*WIDTH-1:WIDTH];
`ifdef ALU_MUL_HI_EN
                                hi_d  = prod[2*WIDTH-1:WIDTH];
`endif
                            end
                            OpAnd:        out_d = in1 & in2;
                            OpOr:         out_d = in1 | in2;
                            OpXor:        out_d = in1 ^ in2;
                            OpDiv, OpRem: out_d = out_q;
                            default:      out_d = out_q;
                        endcase
                    end
                end else if ((state_q == StHold) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (div_done) begin
                    load    = 1'b1;
                    out_d   = is_rem_q ? div_rem : div_quo;
                    dz_d    = div_dz;
                    state_d = StHold;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            out_q    <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            dz_q     <= 1'b0;
            is_rem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (div_start) begin
                is_rem_q <= (op == OpRem);
            end
            if (load) begin
                out_q <= out_d;
                c_q   <= c_d;
                z_q   <= (out_d == '0);
                dz_q  <= dz_d;
            end
        end
    end

`ifdef ALU_MUL_HI_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (load) begin
            hi_q <= hi_d;
        end
    end
    assign out_hi = hi_q;
`else
    assign out_hi = '0;
`endif

    assign out       = out_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_dz   = dz_q;
    assign out_valid = (state_q == StHold);

    alu_div_seq #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (in1),
        .divisor  (in2),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem),
        .dz       (div_dz)
    );

endmodule

// File: doc/alu_seq_nbit.md
Name: alu_seq_nbit

Overview:
- Parametrised successor to the team's 8-bit registered ALU.
- Adds a wider operand width, an 8-op set, a valid/ready handshake on both sides, status flags, and an iterative multi-cycle divider.
- Sits between the operand/opcode source (the stimulus driver or upstream datapath) and the result consumer.
- Holds exactly one result; it never drops or duplicates a transaction.

Parameters:
- WIDTH, 8, operand and result width in bits (legal 4..32).
- OP_W, 3, opcode width (fixed by package; not to be overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset (assert async, deassert sync to clk upstream).
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept a transaction this cycle.
- in1  input  WIDTH  operand A (unsigned).
- in2  input  WIDTH  operand B (unsigned).
- sel  input  OP_W  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 REM, 5 AND, 6 OR, 7 XOR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result, low WIDTH bits.
- out_hi  output  WIDTH  MUL upper half (see Optional Feature).
- flag_c  output  1  carry (ADD) / borrow (SUB) / product overflow (MUL).
- flag_z  output  1  out == 0.
- flag_dz  output  1  divide by zero (DIV/REM with in2 == 0).

Behaviour:
- Reset values: out, out_hi, flags all 0; out_valid = 0; FSM = IDLE; in_ready = 0 while rst_n low.
- FSM states:
  - IDLE: no operation in flight.
  - BUSY: divider iterating.
  - HOLD: result valid, waiting for the consumer.
- in_ready = (state == IDLE) || (state == HOLD && out_ready).
- A transaction is accepted when in_valid && in_ready, with operands sampled at that edge.
- Single-cycle ops (ADD, SUB, MUL, AND, OR, XOR):
  - Result registered on the accept edge; out_valid = 1 the next cycle (latency 1).
  - FSM goes to HOLD.
- DIV/REM:
  - FSM goes to BUSY; restoring divider runs exactly WIDTH iterations, one bit per cycle.
  - On the last iteration the result is registered and the FSM goes to HOLD.
  - Latency from accept edge to out_valid = WIDTH + 1 cycles.
  - in_ready = 0 throughout BUSY.
- HOLD:
  - out, out_hi and flags stay stable until out_valid && out_ready.
  - On that edge: if a new transaction is accepted the same cycle, behave as accept from IDLE (back-to-back, no bubble for single-cycle ops).
  - Otherwise return to IDLE and deassert out_valid.
- Arithmetic (all unsigned, wrap mod 2^WIDTH):
  - ADD: flag_c = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: flag_c = 1 when in1 < in2.
  - MUL: full 2*WIDTH product; out = low half; flag_c = (high half != 0).
  - DIV: out = quotient. REM: out = remainder.
  - Divide by zero (in2 == 0):
    - DIV: out = all ones. REM: out = in1.
    - flag_dz = 1, flag_c = 0; still takes WIDTH + 1 cycles (no early exit).
  - Logic ops: flag_c = 0.
  - flag_z is computed from the registered out for every op.
  - flag_dz = 0 for every non-divide op.
- rst_n low mid-BUSY or mid-HOLD: immediate abort, all outputs to reset values, the pending result is lost.
- in_valid with an unknown/illegal state is impossible: all 8 opcodes are legal.

Optional Feature:
- Macro ALU_MUL_HI_EN.
- Defined: out_hi = upper WIDTH bits of the MUL product; for every other op out_hi = 0.
- Not defined: out_hi tied to 0 for all ops and no high-half register is inferred; the full product is still used internally for flag_c.

Decomposition:
- Shared package alu_pkg:
  - Opcode enum alu_op_e (ADD..XOR, 3 bits).
  - FSM enum alu_state_e (IDLE, BUSY, HOLD).
  - Localparam OP_W = 3.
- One sub-module: alu_div_seq (WIDTH-parametrised restoring divider).
  - Interface: start, dividend, divisor, done, quotient, remainder, dz.
  - Instantiated once and reset by the same rst_n.

Test Plan (WIDTH = 8):
- ADD 200 + 100, out_ready = 1 -> 1 cycle later out = 44, flag_c = 1, flag_z = 0. SUB 5 - 7 -> out = 254, flag_c = 1.
- MUL 20 * 30 with ALU_MUL_HI_EN defined -> out = 88, out_hi = 2, flag_c = 1. Without the macro -> out_hi = 0, flag_c = 1.
- DIV 100 / 7 -> in_ready low for 8 cycles, out_valid on cycle 9, out = 14. REM 100 % 7 -> out = 2.
- DIV 37 / 0 -> out = 255, flag_dz = 1, latency 9. REM 37 % 0 -> out = 37, flag_dz = 1.
- Backpressure: XOR 0xF0 ^ 0xFF with out_ready = 0 for 5 cycles -> out = 0x0F held stable, in_ready = 0. Then out_ready = 1 with a new AND 0x0F & 0x0F presented the same cycle -> accepted, next out = 0x0F, no bubble.
- Reset mid-divide: DIV 255 / 3 accepted, rst_n low on cycle 4 -> out_valid = 0, out = 0 immediately. After release, a new ADD 1 + 1 -> out = 2.
